uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter DATA_W, default 9: maximum data bits per frame (legal 5..9).
REQ-002 SHALL have parameter DIV_W, default 16: width of the baud divisor.
REQ-003 SHALL have port clk, input, 1: rising-edge clock.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port rx_in, input, 1: asynchronous serial line, idle high.
REQ-006 SHALL have port baud_div, input, DIV_W: clk cycles per bit; values below 8 are treated as 8.
REQ-007 SHALL have port data_bits, input, 4: data bits per frame; values below 5 are treated as 5, values above DATA_W as DATA_W.
REQ-008 SHALL have ports parity_en, parity_odd and stop2, each input, 1: enable parity; odd (1) or even (0) parity; two stop bits.
REQ-009 SHALL have port rx_data, output, DATA_W: received word, LSB-aligned, unused upper bits 0.
REQ-010 SHALL have ports rx_valid (output, 1) and rx_ready (input, 1): word handshake.
REQ-011 SHALL have ports parity_err, frame_err, overrun_err and break_det, each output, 1: status of the held word.
REQ-012 SHALL have port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-013 SHALL pass rx_in through a 2-flop synchronizer; all logic below uses the synchronized line.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP1, STOP2 and WAIT_HIGH.
REQ-015 SHALL, in IDLE, detect a 1->0 transition, enter START with bit counter cnt=0 that cycle, and capture baud_div, data_bits, parity_en, parity_odd and stop2; mid-frame changes to these inputs are ignored.
REQ-016 SHALL, with h=baud_div>>1, sample each bit at cnt=h-1, h, h+1 and take the 2-of-3 majority, registered at cnt=h+1; cnt wraps to 0 at baud_div-1.
REQ-017 SHALL, on a majority-1 start bit, return to IDLE (false start) with no output change.
REQ-018 SHALL shift data LSB-first, data_bits bits, then go to PARITY if parity_en is set, else to STOP1.
REQ-019 SHALL flag a parity error when the XOR of the data bits and the parity bit is not parity_odd.
REQ-020 SHALL flag a frame error when STOP1 samples 0, or when STOP2 (entered only if stop2=1) samples 0.
REQ-021 SHALL flag a break when all data bits, the parity bit (if present) and STOP1 are 0; a break also sets the frame error, and the FSM then enters WAIT_HIGH, which returns to IDLE only after the synchronized line reads 1.
REQ-022 SHALL complete a frame at the last stop-bit decision cycle and return to IDLE (or WAIT_HIGH) in the next cycle, so that back-to-back frames are received.
REQ-023 SHALL, on completion with rx_valid low or rx_valid&rx_ready high that cycle, load rx_data and the per-frame flags and set rx_valid in the next cycle.
REQ-024 SHALL hold rx_valid, rx_data and the flags stable until the cycle rx_valid&rx_ready is high; rx_valid then clears unless a new completion loads in that same cycle.
REQ-025 SHALL, on completion while rx_valid=1 and rx_ready=0, discard the new frame, keep the old word, and set overrun_err.
REQ-026 SHALL keep overrun_err set until the accepting handshake.

Reset
REQ-027 SHALL, while reset=0, force the state to IDLE, synchronizer flops to 1, counters to 0, and rx_data, rx_valid, all error flags and busy to 0, including mid-frame.
REQ-028 SHALL, after reset release, require a fresh 1->0 transition to start a frame.

Verification
REQ-029 Bench SHALL cover: baud_div=16, 8N1, byte 0xA5 -> rx_data=0x0A5, rx_valid=1, all flags 0, rx_valid rises 1 cycle after the STOP1 decision cycle.
REQ-030 Bench SHALL cover: data_bits=7, parity_en=1, parity_odd=0, 0x55 sent with wrong parity bit 1 -> rx_data=0x055, parity_err=1.
REQ-031 Bench SHALL cover: stop2=1, second stop bit driven 0 -> frame_err=1, break_det=0.
REQ-032 Bench SHALL cover: rx_in low for a 12-bit time (8N1) -> rx_data=0, frame_err=1, break_det=1, no new frame until rx_in returns high.
REQ-033 Bench SHALL cover: rx_ready=0, frames 0x11 then 0x22 -> rx_data stays 0x011 with overrun_err=1; after the handshake overrun_err=0 and rx_valid=0.
REQ-034 Bench SHALL cover: 4-cycle low glitch with baud_div=16 -> false start, rx_valid stays 0; reset asserted mid-data -> all outputs 0, and the next clean frame is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop line synchronizer, 3-sample majority bit decision,
// runtime frame format latched at each start edge, single-word hold register with overrun.
module uart_rx_cfg #(
    parameter int DATA_W = 9,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_in,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [3:0]        data_bits,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic              stop2,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun_err,
    output logic              break_det,
    output logic              busy
);

    // state       | meaning
    // S_IDLE      | line idle, waiting for a 1->0 edge
    // S_START     | qualifying the start bit (majority 1 = false start)
    // S_DATA      | shifting data bits LSB-first
    // S_PARITY    | sampling the parity bit
    // S_STOP1     | sampling first stop bit; break detection
    // S_STOP2     | sampling second stop bit
    // S_WAIT_HIGH | after a break, waiting for the line to return high
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_WAIT_HIGH
    } state_t;

    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(8);
    localparam logic [3:0]       NB_MAX  = 4'(DATA_W);

    state_t state, state_nx;

    logic              rx_meta, rx_sync, rx_prev;
    logic [DIV_W-1:0]  cfg_div;
    logic [3:0]        cfg_nbits;
    logic              cfg_par_en, cfg_par_odd, cfg_stop2;
    logic [DIV_W-1:0]  cnt;
    logic [3:0]        bit_idx;
    logic              s0, s1;
    logic [DATA_W-1:0] shreg, shreg_ins;
    logic              par_acc, perr_acc, ferr_acc, any_one;

    logic [DIV_W-1:0]  div_eff, half, half_m1, half_p1, div_m1;
    logic [3:0]        nbits_eff;
    logic              maj, dec, active;
    logic              start_det, done, done_ferr, done_brk;
    logic              load, accept;

    assign div_eff   = (baud_div < DIV_MIN) ? DIV_MIN : baud_div;
    assign nbits_eff = (data_bits < 4'd5) ? 4'd5 : ((data_bits > NB_MAX) ? NB_MAX : data_bits);

    assign half    = cfg_div >> 1;
    assign half_m1 = half - ONE;
    assign half_p1 = half + ONE;
    assign div_m1  = cfg_div - ONE;

    assign maj    = (s0 & s1) | (s0 & rx_sync) | (s1 & rx_sync);
    assign active = state inside {S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2};
    assign dec    = active && (cnt == half_p1);
    assign busy   = (state != S_IDLE);

    always_comb begin
        shreg_ins = shreg;
        for (int i = 0; i < DATA_W; i++)
            if (int'(bit_idx) == i) shreg_ins[i] = maj;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        start_det = 1'b0;
        done      = 1'b0;
        done_ferr = 1'b0;
        done_brk  = 1'b0;
        case (state)
            S_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    state_nx  = S_START;
                    start_det = 1'b1;
                end
            end
            S_START: begin
                if (dec) state_nx = maj ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (dec && (bit_idx == cfg_nbits - 4'd1))
                    state_nx = cfg_par_en ? S_PARITY : S_STOP1;
            end
            S_PARITY: begin
                if (dec) state_nx = S_STOP1;
            end
            S_STOP1: begin
                if (dec) begin
                    // an all-zero frame ends here even when two stop bits are configured
                    if (!maj && !any_one) begin
                        state_nx  = S_WAIT_HIGH;
                        done      = 1'b1;
                        done_ferr = 1'b1;
                        done_brk  = 1'b1;
                    end else if (cfg_stop2) begin
                        state_nx = S_STOP2;
                    end else begin
                        state_nx  = S_IDLE;
                        done      = 1'b1;
                        done_ferr = !maj;
                    end
                end
            end
            S_STOP2: begin
                if (dec) begin
                    state_nx  = S_IDLE;
                    done      = 1'b1;
                    done_ferr = ferr_acc | !maj;
                end
            end
            S_WAIT_HIGH: begin
                if (rx_sync) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            rx_prev     <= 1'b1;
            cfg_div     <= '0;
            cfg_nbits   <= '0;
            cfg_par_en  <= 1'b0;
            cfg_par_odd <= 1'b0;
            cfg_stop2   <= 1'b0;
            cnt         <= '0;
            bit_idx     <= '0;
            s0          <= 1'b0;
            s1          <= 1'b0;
            shreg       <= '0;
            par_acc     <= 1'b0;
            perr_acc    <= 1'b0;
            ferr_acc    <= 1'b0;
            any_one     <= 1'b0;
        end else begin
            rx_meta <= rx_in;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            if (start_det) begin
                cfg_div     <= div_eff;
                cfg_nbits   <= nbits_eff;
                cfg_par_en  <= parity_en;
                cfg_par_odd <= parity_odd;
                cfg_stop2   <= stop2;
                cnt         <= '0;
                bit_idx     <= '0;
                shreg       <= '0;
                par_acc     <= 1'b0;
                perr_acc    <= 1'b0;
                ferr_acc    <= 1'b0;
                any_one     <= 1'b0;
            end else if (!active) begin
                cnt <= '0;
            end else begin
                cnt <= (cnt == div_m1) ? '0 : cnt + ONE;
                if (cnt == half_m1) s0 <= rx_sync;
                if (cnt == half)    s1 <= rx_sync;
                if (dec) begin
                    case (state)
                        S_DATA: begin
                            shreg   <= shreg_ins;
                            bit_idx <= bit_idx + 4'd1;
                            par_acc <= par_acc ^ maj;
                            any_one <= any_one | maj;
                        end
                        S_PARITY: begin
                            perr_acc <= (par_acc ^ maj) != cfg_par_odd;
                            any_one  <= any_one | maj;
                        end
                        S_STOP1: ferr_acc <= !maj;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign accept = rx_valid && rx_ready;
    assign load   = done && (!rx_valid || rx_ready);

    // a frame finishing against an unread word is dropped; only the overrun flag records it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            break_det   <= 1'b0;
        end else if (load) begin
            rx_data     <= shreg;
            rx_valid    <= 1'b1;
            parity_err  <= perr_acc;
            frame_err   <= done_ferr;
            break_det   <= done_brk;
            overrun_err <= 1'b0;
        end else if (accept) begin
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            break_det   <= 1'b0;
            overrun_err <= 1'b0;
        end else if (done) begin
            overrun_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: hand-built serial frames with expected words and flags.
module tb_uart_rx_cfg;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_in;
    logic [15:0] baud_div;
    logic [3:0]  data_bits;
    logic        parity_en, parity_odd, stop2;
    logic [8:0]  rx_data;
    logic        rx_valid, rx_ready;
    logic        parity_err, frame_err, overrun_err, break_det, busy;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   rise_cyc = 0;
    int   t0 = 0;
    logic valid_q = 1'b0;

    uart_rx_cfg #(.DATA_W(9), .DIV_W(16)) dut (
        .clk(clk), .reset(reset), .rx_in(rx_in), .baud_div(baud_div),
        .data_bits(data_bits), .parity_en(parity_en), .parity_odd(parity_odd),
        .stop2(stop2), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .parity_err(parity_err), .frame_err(frame_err), .overrun_err(overrun_err),
        .break_det(break_det), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid && !valid_q) rise_cyc = cyc;
        valid_q = rx_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [8:0] d,
                              input logic pe, input logic fe, input logic oe, input logic bk);
        chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
        chk({tag, "_data"},  32'(rx_data), 32'(d));
        chk({tag, "_perr"},  32'(parity_err), 32'(pe));
        chk({tag, "_ferr"},  32'(frame_err), 32'(fe));
        chk({tag, "_ovr"},   32'(overrun_err), 32'(oe));
        chk({tag, "_brk"},   32'(break_det), 32'(bk));
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_valid"}, 32'(rx_valid), 32'd0);
        chk({tag, "_data"},  32'(rx_data), 32'd0);
        chk({tag, "_flags"}, 32'({parity_err, frame_err, overrun_err, break_det}), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
    endtask

    task automatic set_cfg(input logic [15:0] div, input logic [3:0] nb,
                           input logic pen, input logic podd, input logic s2);
        baud_div   = div;
        data_bits  = nb;
        parity_en  = pen;
        parity_odd = podd;
        stop2      = s2;
    endtask

    // bits[0] goes on the line first; each bit lasts div cycles
    task automatic send_bits(input logic [15:0] bits, input int n, input int div);
        for (int i = 0; i < n; i++) begin
            rx_in = bits[i];
            repeat (div) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic accept_word();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        rx_in    = 1'b1;
        rx_ready = 1'b0;
        set_cfg(16'd16, 4'd8, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_cleared("reset");
        reset = 1'b1;
        idle(5);

        // 8N1 0xA5; valid rises 2 sync + 1 detect + 9 bits + (h+2) = 157 cycles after start
        t0 = cyc;
        send_bits(16'({1'b1, 8'hA5, 1'b0}), 10, 16);
        idle(16);
        check_word("a5", 9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("a5_latency", 32'(rise_cyc - t0), 32'd157);
        accept_word();
        chk("a5_accepted", 32'(rx_valid), 32'd0);

        // 7E1 0x55 with wrong parity bit 1
        set_cfg(16'd16, 4'd7, 1'b1, 1'b0, 1'b0);
        send_bits(16'({1'b1, 1'b1, 7'h55, 1'b0}), 10, 16);
        idle(16);
        check_word("par", 9'h055, 1'b1, 1'b0, 1'b0, 1'b0);
        accept_word();

        // 8N2 0x3C with second stop bit low
        set_cfg(16'd16, 4'd8, 1'b0, 1'b0, 1'b1);
        send_bits(16'({1'b0, 1'b1, 8'h3C, 1'b0}), 11, 16);
        idle(16);
        check_word("stop2", 9'h03C, 1'b0, 1'b1, 1'b0, 1'b0);
        accept_word();

        // line low for 12 bit times
        set_cfg(16'd16, 4'd8, 1'b0, 1'b0, 1'b0);
        send_bits(16'h0000, 12, 16);
        check_word("brk", 9'h000, 1'b0, 1'b1, 1'b0, 1'b1);
        accept_word();
        repeat (40) @(negedge clk);
        chk("brk_hold_valid", 32'(rx_valid), 32'd0);
        chk("brk_hold_busy", 32'(busy), 32'd1);
        idle(8);
        chk("brk_released", 32'(busy), 32'd0);
        send_bits(16'({1'b1, 8'h96, 1'b0}), 10, 16);
        idle(16);
        check_word("brk_next", 9'h096, 1'b0, 1'b0, 1'b0, 1'b0);
        accept_word();

        // two frames with nobody reading
        send_bits(16'({1'b1, 8'h11, 1'b0}), 10, 16);
        idle(16);
        send_bits(16'({1'b1, 8'h22, 1'b0}), 10, 16);
        idle(16);
        check_word("ovr", 9'h011, 1'b0, 1'b0, 1'b1, 1'b0);
        accept_word();
        chk("ovr_cleared", 32'(overrun_err), 32'd0);
        chk("ovr_valid", 32'(rx_valid), 32'd0);

        // 4-cycle glitch is a false start
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        idle(60);
        chk("glitch_valid", 32'(rx_valid), 32'd0);
        chk("glitch_busy", 32'(busy), 32'd0);

        // baud_div 3 behaves as 8, data_bits 15 behaves as 9
        set_cfg(16'd3, 4'd15, 1'b0, 1'b0, 1'b0);
        send_bits(16'({1'b1, 9'h1A5, 1'b0}), 11, 8);
        idle(16);
        check_word("clamp", 9'h1A5, 1'b0, 1'b0, 1'b0, 1'b0);

        // reset in the middle of a data bit while a word is still held
        set_cfg(16'd16, 4'd8, 1'b0, 1'b0, 1'b0);
        send_bits(16'({1'b1, 8'hFF, 1'b0}), 4, 16);
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check_cleared("mid_reset");
        @(negedge clk);
        rx_in = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        idle(8);
        send_bits(16'({1'b1, 8'h5A, 1'b0}), 10, 16);
        idle(16);
        check_word("post_rst", 9'h05A, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
